// File: rtl/tt10_pkg.sv
// Shared tt10 definitions: data widths, buffer entry type and the receive-side decode.
package tt10_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned SHIFT_BIT = 7;
    localparam int unsigned DEPTH     = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } entry_t;

    // Shifted bytes had A[7] pushed out and a 0 shifted in; a set LSB means a framing error.
    function automatic entry_t tt10_decode(input logic [DATA_W-1:0] c,
                                           input logic              shift,
                                           input logic [DATA_W-1:0] key);
        entry_t e;
        if (shift) begin
            e.data[SHIFT_BIT]     = 1'b1;
            e.data[SHIFT_BIT-1:0] = c[DATA_W-1:1] ^ key[SHIFT_BIT-1:0];
            e.err                 = c[0];
        end else begin
            e.data = c ^ key;
            e.err  = 1'b0;
        end
        return e;
    endfunction

endpackage

// File: rtl/tt10_fifo2.sv
// Two-entry synchronous FIFO of decoded entries with occupancy count.
module tt10_fifo2
    import tt10_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tt10_decoder.sv
// tt10 receive-side decoder: key register, decode, 2-entry output buffer and
// bring-up counters for decoded bytes and framing errors.
module tt10_decoder
    import tt10_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_shift,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  byte_count,
    output logic [ERR_W-1:0]  err_count
);

    logic [DATA_W-1:0] key_q, key_d;
    logic [CNT_W-1:0]  byte_count_q, byte_count_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;

    logic   accept, pop, full, empty;
    entry_t dec, head;

    // in_ready depends only on buffer occupancy state, never on out_ready.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign dec       = tt10_decode(in_data, in_shift, key_q);

    tt10_fifo2 u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (accept),
        .wdata_i (dec),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        key_d        = key_load ? key_in : key_q;
        byte_count_d = byte_count_q + CNT_W'(accept);
        err_count_d  = err_count_q;
        if (accept && dec.err && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q        <= '0;
            byte_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            key_q        <= key_d;
            byte_count_q <= byte_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_data   = empty ? '0 : head.data;
    assign out_err    = empty ? 1'b0 : head.err;
    assign byte_count = byte_count_q;
    assign err_count  = err_count_q;

endmodule

// File: doc/tt10_decoder.md
Name: tt10_decoder

Overview:
Receive-side inverse of the tt10 XOR/shift encoder (encoder: C = A^B, then C<<1 when A[7]=1). Recovers plaintext A from encoded byte C, the shared key B and a per-byte shift flag. Streams with valid/ready on both sides through a 2-entry output buffer, and keeps decoded-byte and framing-error counters for bring-up visibility.

Parameters:
DEPTH, 2, output buffer entries (fixed at 2 for this block; power of two)
CNT_W, 16, width of decoded-byte counter (wraps)
ERR_W, 8, width of error counter (saturates)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
key_in  input  8  new key value B
key_load  input  1  load key_in into key register this cycle
in_data  input  8  encoded byte C
in_shift  input  1  1 = C was produced with shift (A[7]=1)
in_valid  input  1  input byte present
in_ready  output  1  decoder can accept; registered, equals !full
out_data  output  8  decoded byte A at buffer head
out_err  output  1  framing error flag for head byte
out_valid  output  1  buffer non-empty
out_ready  input  1  consumer accepts head byte
byte_count  output  CNT_W  total bytes pushed into buffer, wraps
err_count  output  ERR_W  total error bytes pushed, saturates at all-ones

Behaviour:
- Reset (rst=1 at edge): key=0x00, buffer empty, in_ready=1, out_valid=0, out_data=0x00, out_err=0, byte_count=0, err_count=0. Reset mid-transfer discards buffered bytes; no output fires on the reset edge.
- Accept when in_valid & in_ready; pop when out_valid & out_ready.
- Decode (combinational on accepted input, current key register):
  - in_shift=0: A = C ^ key.
  - in_shift=1: A[7] = 1; A[6:0] = C[7:1] ^ key[6:0]; err = C[0] (encoder always shifts in 0).
  - in_shift=0: err = 0.
- key_load in same cycle as an accept: the accepted byte uses the OLD key; the new key applies from the next cycle.
- Latency: byte accepted at edge N is visible on out_data/out_valid after edge N (1 cycle); in FIFO order.
- Buffer: 2 entries {A, err}, read/write pointers plus occupancy count 0..2.
  - empty & push: count=1. count=1 push & pop: count stays 1, head advances. count=2: in_ready=0, no push; pop -> count=1, in_ready=1 next cycle.
  - Pop when empty is impossible (out_valid=0). in_ready has no combinational path from out_ready.
- out_data/out_err are driven from the head entry when out_valid=1 and are 0 when empty.
- Counters: byte_count +1 per accept, wraps 0xFFFF->0. err_count +1 per accept with err=1; holds at 0xFF.

Decomposition:
- Package tt10_pkg: constants DATA_W=8, SHIFT_BIT=7, DEPTH=2; typedef entry_t {logic [7:0] data; logic err;}; function tt10_decode(c, shift, key) returning entry_t. The encoder shares the package later.
- One sub-module, tt10_fifo2: a 2-entry synchronous FIFO of entry_t with push/pop/full/empty. The decode function, key register and counters stay in tt10_decoder.

Test Plan:
- key_load 0x33; in 0x66 shift=0 -> out_data 0x55, err=0, valid 1 cycle after accept; byte_count=1.
- key 0x33; in 0xCC shift=1 -> out_data 0xD5, err=0; in 0xCD shift=1 -> 0xD5, err=1, err_count=1.
- key 0xFF; in 0x00 shift=0 -> 0xFF; same-cycle key_load 0x0F with in 0x00 -> 0xFF (old key); next in 0x00 -> 0x0F.
- out_ready=0, stream 3 bytes -> in_ready low after 2 accepts, third held; out_ready=1 -> bytes drain in order, third accepted one cycle after first pop.
- Continuous in_valid/out_ready=1 for 300 cycles -> one byte per cycle, count never exceeds 1; inject 256+ errors -> err_count stays 0xFF.
- rst asserted with 2 bytes buffered -> next cycle out_valid=0, in_ready=1, counters 0, key 0x00.
